// File: rtl/lockstep_monitor.sv
// Replica comparator/voter: forwards a resolved bundle, attributes faults, counts discrepancies
// and pulses the discrepancy reset. Optional majority voting is enabled by LOCKSTEP_VOTE_EN.
module lockstep_monitor #(
  parameter int WIDTH      = 32,
  parameter int REPLICAS   = 3,
  parameter int TOLERANCE  = 0,
  parameter int RST_CYCLES = 4,
  parameter int CNT_W      = 8
) (
  input  logic                      s_clk_i,
  input  logic                      s_rst_i,
  input  logic                      s_valid_i,
  input  logic [REPLICAS*WIDTH-1:0] s_data_i,
  input  logic                      s_clear_i,
  output logic [WIDTH-1:0]          s_data_o,
  output logic [REPLICAS-1:0]       s_fault_o,
  output logic [CNT_W-1:0]          s_err_cnt_o,
  output logic                      s_hrdmax_rst_o
);

  localparam int RUN_W   = $clog2(TOLERANCE + 2);
  localparam int PULSE_W = $clog2(RST_CYCLES + 1);

  typedef enum logic [1:0] {ST_OK, ST_SUSPECT, ST_RST} state_t;

  state_t               state, state_nxt;
  logic [RUN_W-1:0]     run, run_nxt;
  logic [PULSE_W-1:0]   pulse, pulse_nxt;
  logic [REPLICAS-1:0]  fault_nxt;
  logic [CNT_W-1:0]     cnt_nxt;

  logic                 all_eq;
  logic                 corr;
  logic [REPLICAS-1:0]  minority;
  logic [WIDTH-1:0]     voted;
  logic                 uncorr;

  always_comb begin
    all_eq = 1'b1;
    for (int k = 1; k < REPLICAS; k++) begin
      if (s_data_i[k*WIDTH +: WIDTH] != s_data_i[0 +: WIDTH]) all_eq = 1'b0;
    end
  end

`ifdef LOCKSTEP_VOTE_EN
  if (REPLICAS == 3) begin : g_vote
    logic [WIDTH-1:0] r0, r1, r2;
    assign r0 = s_data_i[0 +: WIDTH];
    assign r1 = s_data_i[WIDTH +: WIDTH];
    assign r2 = s_data_i[2*WIDTH +: WIDTH];

    // With all_eq false, at most one of these pairings can hold.
    always_comb begin
      corr     = 1'b0;
      minority = '0;
      voted    = r0;
      if (!all_eq) begin
        if (r0 == r1) begin
          corr = 1'b1; minority[2] = 1'b1;
        end else if (r0 == r2) begin
          corr = 1'b1; minority[1] = 1'b1;
        end else if (r1 == r2) begin
          corr = 1'b1; minority[0] = 1'b1; voted = r1;
        end
      end
    end
  end else begin : g_novote
    assign corr     = 1'b0;
    assign minority = '0;
    assign voted    = s_data_i[0 +: WIDTH];
  end
`else
  assign corr     = 1'b0;
  assign minority = '0;
  assign voted    = s_data_i[0 +: WIDTH];
`endif

  assign s_data_o = voted;
  assign uncorr   = s_valid_i & ~all_eq & ~corr;

  always_comb begin
    state_nxt = state;
    run_nxt   = run;
    pulse_nxt = pulse;
    fault_nxt = s_clear_i ? '0 : s_fault_o;
    cnt_nxt   = s_clear_i ? '0 : s_err_cnt_o;
    case (state)
      ST_RST: begin
        if (pulse <= PULSE_W'(1)) begin
          state_nxt = ST_OK;
          run_nxt   = '0;
          pulse_nxt = '0;
        end else begin
          pulse_nxt = pulse - 1'b1;
        end
      end
      default: begin
        if (s_valid_i && !all_eq) begin
          if (cnt_nxt != '1) cnt_nxt = cnt_nxt + 1'b1;
          fault_nxt = fault_nxt | (corr ? minority : '1);
        end
        if (uncorr) begin
          if (int'(run) + 1 > TOLERANCE) begin
            state_nxt = ST_RST;
            pulse_nxt = PULSE_W'(RST_CYCLES);
            run_nxt   = '0;
          end else begin
            state_nxt = ST_SUSPECT;
            run_nxt   = run + 1'b1;
          end
        end else if (s_valid_i) begin
          state_nxt = ST_OK;
          run_nxt   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge s_clk_i) begin
    if (s_rst_i) begin
      state          <= ST_OK;
      run            <= '0;
      pulse          <= '0;
      s_fault_o      <= '0;
      s_err_cnt_o    <= '0;
      s_hrdmax_rst_o <= 1'b0;
    end else begin
      state          <= state_nxt;
      run            <= run_nxt;
      pulse          <= pulse_nxt;
      s_fault_o      <= fault_nxt;
      s_err_cnt_o    <= cnt_nxt;
      s_hrdmax_rst_o <= (state_nxt == ST_RST);
    end
  end

endmodule

// File: tb/tb_lockstep_monitor.sv
// Scoreboard bench: a triple-replica instance (TOLERANCE=2) and a dual-replica instance
// (TOLERANCE=0, CNT_W=2) share stimulus; a reference model predicts every cycle.
module tb_lockstep_monitor;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, valid, clear;
  logic [95:0] din;

  logic [31:0] data_a, data_b;
  logic [2:0]  fault_a;
  logic [1:0]  fault_b;
  logic [7:0]  cnt_a;
  logic [1:0]  cnt_b;
  logic        hr_a, hr_b;

  lockstep_monitor #(.WIDTH(32), .REPLICAS(3), .TOLERANCE(2), .RST_CYCLES(4), .CNT_W(8)) u_a (
    .s_clk_i(clk), .s_rst_i(rst), .s_valid_i(valid), .s_data_i(din), .s_clear_i(clear),
    .s_data_o(data_a), .s_fault_o(fault_a), .s_err_cnt_o(cnt_a), .s_hrdmax_rst_o(hr_a));

  lockstep_monitor #(.WIDTH(32), .REPLICAS(2), .TOLERANCE(0), .RST_CYCLES(4), .CNT_W(2)) u_b (
    .s_clk_i(clk), .s_rst_i(rst), .s_valid_i(valid), .s_data_i(din[63:0]), .s_clear_i(clear),
    .s_data_o(data_b), .s_fault_o(fault_b), .s_err_cnt_o(cnt_b), .s_hrdmax_rst_o(hr_b));

`ifdef LOCKSTEP_VOTE_EN
  localparam bit VOTE = 1'b1;
`else
  localparam bit VOTE = 1'b0;
`endif
  localparam int RC = 4;

  int p_rep[2] = '{3, 2};
  int p_tol[2] = '{2, 0};
  int p_cw[2]  = '{8, 2};

  int       m_state[2];
  int       m_run[2];
  int       m_pulse[2];
  int       m_cnt[2];
  logic [2:0] m_fault[2];

  typedef struct {
    int         inst;
    logic [2:0] fault;
    int         cnt;
    logic       hr;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // cls: 0 match, 1 correctable, 2 uncorrectable
  task automatic classify(input int inst, input logic [31:0] d0, d1, d2,
                          output int cls, output logic [2:0] mb, output logic [31:0] dx);
    mb = 3'b000;
    dx = d0;
    if (p_rep[inst] == 2)                 cls = (d0 == d1) ? 0 : 2;
    else if (d0 == d1 && d1 == d2)        cls = 0;
    else if (!VOTE)                       cls = 2;
    else if (d0 == d1) begin cls = 1; mb = 3'b100; end
    else if (d0 == d2) begin cls = 1; mb = 3'b010; end
    else if (d1 == d2) begin cls = 1; mb = 3'b001; dx = d1; end
    else                                  cls = 2;
  endtask

  task automatic model_step(input int i, input int cls, input logic [2:0] mb,
                            input logic v, c, r);
    logic [2:0] full;
    int         cmax;
    full = (p_rep[i] == 3) ? 3'b111 : 3'b011;
    cmax = (1 << p_cw[i]) - 1;
    if (r) begin
      m_state[i] = 0; m_run[i] = 0; m_pulse[i] = 0; m_cnt[i] = 0; m_fault[i] = 3'b000;
    end else begin
      if (c) begin m_fault[i] = 3'b000; m_cnt[i] = 0; end
      if (m_state[i] == 2) begin
        if (m_pulse[i] <= 1) begin m_state[i] = 0; m_run[i] = 0; m_pulse[i] = 0; end
        else m_pulse[i]--;
      end else if (v) begin
        if (cls == 0) begin
          m_run[i] = 0; m_state[i] = 0;
        end else begin
          if (m_cnt[i] < cmax) m_cnt[i]++;
          if (cls == 1) begin
            m_fault[i] = m_fault[i] | mb; m_run[i] = 0; m_state[i] = 0;
          end else begin
            m_fault[i] = m_fault[i] | full;
            if (m_run[i] + 1 > p_tol[i]) begin
              m_state[i] = 2; m_pulse[i] = RC; m_run[i] = 0;
            end else begin
              m_run[i]++; m_state[i] = 1;
            end
          end
        end
      end
    end
  endtask

  task automatic step(input logic [31:0] d0, d1, d2, input logic v, c, r);
    exp_t       e;
    int         cls;
    logic [2:0] mb;
    logic [31:0] dx;
    din   = {d2, d1, d0};
    valid = v;
    clear = c;
    rst   = r;
    #1;
    for (int i = 0; i < 2; i++) begin
      classify(i, d0, d1, d2, cls, mb, dx);
      check_val(i == 0 ? "data_a" : "data_b", i == 0 ? data_a : data_b, dx);
      model_step(i, cls, mb, v, c, r);
      e.inst = i; e.fault = m_fault[i]; e.cnt = m_cnt[i]; e.hr = (m_state[i] == 2);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.inst == 0) begin
        check_val("fault_a", fault_a, e.fault);
        check_val("cnt_a",   cnt_a,   e.cnt);
        check_val("hr_a",    hr_a,    e.hr);
      end else begin
        check_val("fault_b", fault_b, e.fault);
        check_val("cnt_b",   cnt_b,   e.cnt);
        check_val("hr_b",    hr_b,    e.hr);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(32'hA5A5_0000, 32'hA5A5_0000, 32'hA5A5_0000, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic mism();
    step(32'h0, 32'h1, 32'h2, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; clear = 1'b0; din = '0;
    for (int i = 0; i < 2; i++) begin
      m_state[i] = 0; m_run[i] = 0; m_pulse[i] = 0; m_cnt[i] = 0; m_fault[i] = 3'b000;
    end
    step(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(10);

    // single-replica disagreement, then let any pulse drain
    step(32'h0, 32'h1, 32'h0, 1'b1, 1'b0, 1'b0);
    idle(6);
    step(32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

    // tolerance run: U, U, M, U, U, U
    mism(); mism(); idle(1); mism(); mism(); mism();
    idle(6);

    // saturation: five mismatches separated by full pulses
    for (int k = 0; k < 5; k++) begin mism(); idle(5); end

    // reset during the second pulse cycle
    mism(); mism(); mism();
    step(32'h0, 32'h1, 32'h2, 1'b1, 1'b0, 1'b0);
    step(32'h0, 32'h1, 32'h2, 1'b1, 1'b0, 1'b1);
    idle(3);

    // clear during a pulse: flags drop, pulse continues
    mism(); mism(); mism();
    step(32'h0, 32'h1, 32'h2, 1'b1, 1'b1, 1'b0);
    idle(6);

    // clear together with an event
    step(32'h0, 32'h0, 32'h7, 1'b1, 1'b1, 1'b0);
    idle(6);

    // valid low holds the run counter
    mism(); step(32'h0, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0); mism(); idle(6);

    for (int k = 0; k < 400; k++) begin
      step(32'($urandom_range(0, 1)), 32'($urandom_range(0, 1)), 32'($urandom_range(0, 2)),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
